// File: rtl/reg_abi_name_pkg.sv
// Shared constants, name type and the ABI mnemonic table for reg_abi_name.
// Names are ASCII, right-justified, NUL-padded, first character in the highest occupied byte.
package getreg_pkg;

   localparam int NAME_W = 32;
   localparam int IDX_W  = 6;

   typedef logic [NAME_W-1:0] abi_name_t;

   localparam abi_name_t FP_ALIAS = 32'h0000_6670;

   localparam abi_name_t ABI_NAME [32] = '{
      32'h7A65_726F, 32'h0000_7261, 32'h0000_7370, 32'h0000_6770,
      32'h0000_7470, 32'h0000_7430, 32'h0000_7431, 32'h0000_7432,
      32'h0000_7330, 32'h0000_7331, 32'h0000_6130, 32'h0000_6131,
      32'h0000_6132, 32'h0000_6133, 32'h0000_6134, 32'h0000_6135,
      32'h0000_6136, 32'h0000_6137, 32'h0000_7332, 32'h0000_7333,
      32'h0000_7334, 32'h0000_7335, 32'h0000_7336, 32'h0000_7337,
      32'h0000_7338, 32'h0000_7339, 32'h0073_3130, 32'h0073_3131,
      32'h0000_7433, 32'h0000_7434, 32'h0000_7435, 32'h0000_7436
   };

   function automatic abi_name_t idx2name(logic [4:0] idx);
      return ABI_NAME[idx];
   endfunction

endpackage

// File: rtl/reg_abi_name_if.sv
// Request/response bundle for reg_abi_name: forward index->name and reverse name->index lookups.
interface reg_abi_name_if;
   import getreg_pkg::*;

   logic             req_valid_i;
   logic [IDX_W-1:0] req_idx_i;
   logic             rsp_valid_o;
   abi_name_t        rsp_name_o;
   logic             rsp_err_o;

   logic             rev_valid_i;
   abi_name_t        rev_name_i;
   logic             rev_valid_o;
   logic [4:0]       rev_idx_o;
   logic             rev_hit_o;

   modport master (
      output req_valid_i, req_idx_i, rev_valid_i, rev_name_i,
      input  rsp_valid_o, rsp_name_o, rsp_err_o, rev_valid_o, rev_idx_o, rev_hit_o
   );

   modport slave (
      input  req_valid_i, req_idx_i, rev_valid_i, rev_name_i,
      output rsp_valid_o, rsp_name_o, rsp_err_o, rev_valid_o, rev_idx_o, rev_hit_o
   );

endinterface

// File: rtl/reg_abi_name_rom.sv
// Combinational 32-entry index -> ABI name table used by the forward lookup path.
module reg_name_rom
   import getreg_pkg::*;
(
   input  logic [4:0] idx_i,
   output abi_name_t  name_o
);

   always_comb begin
      name_o = '0;
      case (idx_i)
         5'd0:  name_o = 32'h7A65_726F;
         5'd1:  name_o = 32'h0000_7261;
         5'd2:  name_o = 32'h0000_7370;
         5'd3:  name_o = 32'h0000_6770;
         5'd4:  name_o = 32'h0000_7470;
         5'd5:  name_o = 32'h0000_7430;
         5'd6:  name_o = 32'h0000_7431;
         5'd7:  name_o = 32'h0000_7432;
         5'd8:  name_o = 32'h0000_7330;
         5'd9:  name_o = 32'h0000_7331;
         5'd10: name_o = 32'h0000_6130;
         5'd11: name_o = 32'h0000_6131;
         5'd12: name_o = 32'h0000_6132;
         5'd13: name_o = 32'h0000_6133;
         5'd14: name_o = 32'h0000_6134;
         5'd15: name_o = 32'h0000_6135;
         5'd16: name_o = 32'h0000_6136;
         5'd17: name_o = 32'h0000_6137;
         5'd18: name_o = 32'h0000_7332;
         5'd19: name_o = 32'h0000_7333;
         5'd20: name_o = 32'h0000_7334;
         5'd21: name_o = 32'h0000_7335;
         5'd22: name_o = 32'h0000_7336;
         5'd23: name_o = 32'h0000_7337;
         5'd24: name_o = 32'h0000_7338;
         5'd25: name_o = 32'h0000_7339;
         5'd26: name_o = 32'h0073_3130;
         5'd27: name_o = 32'h0073_3131;
         5'd28: name_o = 32'h0000_7433;
         5'd29: name_o = 32'h0000_7434;
         5'd30: name_o = 32'h0000_7435;
         5'd31: name_o = 32'h0000_7436;
         default: name_o = '0;
      endcase
   end

endmodule

// File: rtl/reg_abi_name.sv
// RISC-V register index <-> ABI mnemonic lookup, 1-cycle registered latency on both paths.
// Reverse (name -> index) path is built only when GETREG_REVERSE_EN is defined; otherwise rev_* outputs are 0.
module reg_abi_name
   import getreg_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   reg_abi_name_if.slave bus
);

   abi_name_t romName;

   logic      rsp_valid_q, rsp_valid_d;
   abi_name_t rsp_name_q,  rsp_name_d;
   logic      rsp_err_q,   rsp_err_d;

   reg_name_rom u_rom (
      .idx_i  (bus.req_idx_i[4:0]),
      .name_o (romName)
   );

   // Name and error flag hold their last values while no request is presented.
   always_comb begin
      rsp_valid_d = bus.req_valid_i;
      rsp_name_d  = rsp_name_q;
      rsp_err_d   = rsp_err_q;
      if (bus.req_valid_i) begin
         if (bus.req_idx_i[5]) begin
            rsp_name_d = '0;
            rsp_err_d  = 1'b1;
         end else begin
            rsp_name_d = romName;
            rsp_err_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_name_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_name_q  <= rsp_name_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_name_o  = rsp_name_q;
   assign bus.rsp_err_o   = rsp_err_q;

`ifdef GETREG_REVERSE_EN
   logic       rev_valid_q, rev_valid_d;
   logic [4:0] rev_idx_q,   rev_idx_d;
   logic       rev_hit_q,   rev_hit_d;

   // Exact 32-bit compare: padding other than leading NULs never matches.
   always_comb begin
      rev_valid_d = bus.rev_valid_i;
      rev_idx_d   = rev_idx_q;
      rev_hit_d   = rev_hit_q;
      if (bus.rev_valid_i) begin
         rev_idx_d = '0;
         rev_hit_d = 1'b0;
         for (int i = 0; i < 32; i++) begin
            if (bus.rev_name_i == ABI_NAME[i]) begin
               rev_idx_d = 5'(i);
               rev_hit_d = 1'b1;
            end
         end
         if (bus.rev_name_i == FP_ALIAS) begin
            rev_idx_d = 5'd8;
            rev_hit_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rev_valid_q <= 1'b0;
         rev_idx_q   <= '0;
         rev_hit_q   <= 1'b0;
      end else begin
         rev_valid_q <= rev_valid_d;
         rev_idx_q   <= rev_idx_d;
         rev_hit_q   <= rev_hit_d;
      end
   end

   assign bus.rev_valid_o = rev_valid_q;
   assign bus.rev_idx_o   = rev_idx_q;
   assign bus.rev_hit_o   = rev_hit_q;
`else
   logic unused_rev;
   assign unused_rev = ^{bus.rev_valid_i, bus.rev_name_i};

   assign bus.rev_valid_o = 1'b0;
   assign bus.rev_idx_o   = '0;
   assign bus.rev_hit_o   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_abi_name.sv
// Scoreboard testbench for reg_abi_name; reverse-path checks are enabled with GETREG_REVERSE_EN.
// Expected responses come from a string-based model of the ABI naming rules.
module tb_reg_abi_name;
   import getreg_pkg::*;

   typedef struct {
      logic [31:0] name;
      logic        err;
      int          due;
   } fwdExp_t;

   typedef struct {
      logic [4:0] idx;
      logic       hit;
      int         due;
   } revExp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   testsRun = 0;
   int   testsFailed = 0;

   fwdExp_t fwdQ[$];
   revExp_t revQ[$];

   string abiNames [32] = '{
      "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
      "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
      "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
      "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
   };

   reg_abi_name_if bus ();

   reg_abi_name dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pack a mnemonic: first char ends up in the highest occupied byte, NULs above.
   function automatic logic [31:0] name2bits(string s);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < s.len(); i++) v = {v[23:0], s[i]};
      return v;
   endfunction

   function automatic void revModel(input logic [31:0] n, output logic hit, output logic [4:0] idx);
      hit = 1'b0;
      idx = '0;
      for (int k = 0; k < 32; k++) begin
         if (name2bits(abiNames[k]) == n) begin
            hit = 1'b1;
            idx = 5'(k);
         end
      end
      if (n == name2bits("fp")) begin
         hit = 1'b1;
         idx = 5'd8;
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Drive one cycle of requests, record the expected responses, then advance to the next negedge.
   task automatic applyStimulus(input logic v, input logic [5:0] idx, input logic rv, input logic [31:0] rn);
      fwdExp_t fe;
      revExp_t re;
      logic    h;
      logic [4:0] ri;
      bus.req_valid_i = v;
      bus.req_idx_i   = idx;
      bus.rev_valid_i = rv;
      bus.rev_name_i  = rn;
      if (rst_n && v) begin
         fe.due  = cyc + 1;
         fe.err  = idx[5];
         fe.name = idx[5] ? 32'h0 : name2bits(abiNames[idx[4:0]]);
         fwdQ.push_back(fe);
      end
`ifdef GETREG_REVERSE_EN
      if (rst_n && rv) begin
         revModel(rn, h, ri);
         re.due = cyc + 1;
         re.hit = h;
         re.idx = ri;
         revQ.push_back(re);
      end
`else
      h  = 1'b0;
      ri = '0;
      re.due = 0;
      re.hit = h;
      re.idx = ri;
`endif
      @(negedge clk);
   endtask

   task automatic midStreamReset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", {23'h0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_name_o,
                                  bus.rev_valid_o, bus.rev_hit_o, bus.rev_idx_o}, 64'h0);
      fwdQ.delete();
      revQ.delete();
      bus.req_valid_i = 1'b0;
      bus.rev_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b0, 6'd0, 1'b0, 32'h0);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a response.
   always @(negedge clk) begin
      fwdExp_t fe;
      revExp_t re;
      if (!rst_n) begin
         checkOutput("reset_zero", {23'h0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_name_o,
                                    bus.rev_valid_o, bus.rev_hit_o, bus.rev_idx_o}, 64'h0);
      end else begin
         if (bus.rsp_valid_o) begin
            if (fwdQ.size() == 0) checkOutput("fwd_unexpected", 64'd1, 64'd0);
            else begin
               fe = fwdQ.pop_front();
               checkOutput("fwd_latency", 64'(cyc), 64'(fe.due));
               checkOutput("fwd_name", {32'h0, bus.rsp_name_o}, {32'h0, fe.name});
               checkOutput("fwd_err", {63'h0, bus.rsp_err_o}, {63'h0, fe.err});
            end
         end else if (fwdQ.size() > 0 && fwdQ[0].due <= cyc) begin
            fe = fwdQ.pop_front();
            checkOutput("fwd_missing", 64'd0, 64'd1);
         end
`ifdef GETREG_REVERSE_EN
         if (bus.rev_valid_o) begin
            if (revQ.size() == 0) checkOutput("rev_unexpected", 64'd1, 64'd0);
            else begin
               re = revQ.pop_front();
               checkOutput("rev_latency", 64'(cyc), 64'(re.due));
               checkOutput("rev_hit", {63'h0, bus.rev_hit_o}, {63'h0, re.hit});
               checkOutput("rev_idx", {59'h0, bus.rev_idx_o}, {59'h0, re.idx});
            end
         end else if (revQ.size() > 0 && revQ[0].due <= cyc) begin
            re = revQ.pop_front();
            checkOutput("rev_missing", 64'd0, 64'd1);
         end
`else
         checkOutput("rev_tied", {57'h0, bus.rev_valid_o, bus.rev_hit_o, bus.rev_idx_o}, 64'h0);
`endif
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] names [$];
      bus.req_valid_i = 1'b1;
      bus.req_idx_i   = 6'd5;
      bus.rev_valid_i = 1'b1;
      bus.rev_name_i  = 32'h0000_6130;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 6'd5, 1'b1, 32'h0000_6130);

      for (int i = 0; i < 32; i++) applyStimulus(1'b1, 6'(i), 1'b0, 32'h0);
      applyStimulus(1'b1, 6'd32, 1'b0, 32'h0);
      applyStimulus(1'b1, 6'd63, 1'b0, 32'h0);
      applyStimulus(1'b0, 6'd1, 1'b0, 32'h0);
      applyStimulus(1'b1, 6'd27, 1'b0, 32'h0);

      names = '{name2bits("a0"), name2bits("fp"), name2bits("s10"), name2bits("x5"),
                name2bits("zero"), 32'h6130_2020, 32'h0020_7370};
      foreach (names[k]) applyStimulus(1'b1, 6'(k + 3), 1'b1, names[k]);

      for (int i = 0; i < 32; i++) applyStimulus(1'b0, 6'd0, 1'b1, idx2name(5'(i)));

      for (int n = 0; n < 600; n++) begin
         logic [31:0] rn;
         case ($urandom_range(0, 4))
            0, 1:    rn = name2bits(abiNames[$urandom_range(0, 31)]);
            2:       rn = name2bits("fp");
            3:       rn = $urandom;
            default: rn = {name2bits(abiNames[$urandom_range(0, 31)]), 8'h20};
         endcase
         applyStimulus($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
                       $urandom_range(0, 2) != 0, rn);
         if (n == 300) begin
            applyStimulus(1'b1, 6'd9, 1'b1, name2bits("t6"));
            midStreamReset();
         end
      end

      repeat (3) applyStimulus(1'b0, 6'd0, 1'b0, 32'h0);
      checkOutput("fwd_drain", 64'(fwdQ.size()), 64'd0);
      checkOutput("rev_drain", 64'(revQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
